// File: rtl/pix_pkg.sv
// Shared pixel-format constants and Gaussian kernel arithmetic for the camera pixel pipeline.
// The default geometry of 640x480 = 307200 pixels fits the 19-bit frame-buffer address.
package pix_pkg;
    localparam int PIX_W      = 12;
    localparam int CH_W       = 4;
    localparam int N_CH       = PIX_W / CH_W;
    localparam int DEF_IMG_W  = 640;
    localparam int DEF_IMG_H  = 480;
    localparam int DEF_ADDR_W = 19;

    // One kernel row: 1-2-1 weighting, at most 60.
    function automatic logic [5:0] row_sum(input logic [CH_W-1:0] a,
                                           input logic [CH_W-1:0] b,
                                           input logic [CH_W-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // Weighted sum of the three row sums, at most 240, divided by 16 with truncation.
    function automatic logic [CH_W-1:0] kernel_out(input logic [5:0] top,
                                                   input logic [5:0] mid,
                                                   input logic [5:0] bot);
        logic [7:0] s;
        s = {2'b00, top} + {1'b0, mid, 1'b0} + {2'b00, bot};
        return s[7:4];
    endfunction
endpackage

// File: rtl/pix_line_buf.sv
// Single-clock line buffer with combinational read, so a read in the write cycle returns the old word.
module pix_line_buf
    import pix_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             pclk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge pclk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/pix_gauss3x3.sv
// Streaming 3x3 Gaussian smoother for RGB444 pixels with per-frame raw bypass.
// Output appears two pclk cycles after the input pixel that completes its window.
module pix_gauss3x3
    import pix_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              filt_en,
    input  logic              pix_en,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              out_en,
    output logic [PIX_W-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

    logic [1:0]        vs_sh;
    logic              frame_start;
    logic              frame_active;
    logic              mode_q;
    logic              accept;
    logic              win_done;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] base_q;

    logic [PIX_W-1:0]  lb0_rd;
    logic [PIX_W-1:0]  lb1_rd;
    logic [PIX_W-1:0]  ncol [3];
    logic [PIX_W-1:0]  win [3][2];

    logic [5:0]        s1_sum [3][N_CH];
    logic [PIX_W-1:0]  s1_centre;
    logic              s1_pass;
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [PIX_W-1:0]  filt;

    assign frame_start = (vs_sh == 2'b01);
    assign accept      = pix_en & frame_active & ~frame_start;
    assign win_done    = (row != '0) && (col != '0);

    always_comb begin
        ncol[0] = lb1_rd;
        ncol[1] = lb0_rd;
        ncol[2] = pix_data;
    end

    pix_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
        .pclk  (pclk),
        .we    (accept),
        .addr  (col),
        .wdata (pix_data),
        .rdata (lb0_rd)
    );

    pix_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .pclk  (pclk),
        .we    (accept),
        .addr  (col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // base_q tracks (row-1)*IMG_W so the window address needs no multiplier.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_sh        <= 2'b00;
            frame_active <= 1'b0;
            mode_q       <= 1'b0;
            col          <= '0;
            row          <= '0;
            base_q       <= '0;
        end else begin
            vs_sh <= {vs_sh[0], vsync};
            if (frame_start) begin
                frame_active <= 1'b1;
                mode_q       <= filt_en;
                col          <= '0;
                row          <= '0;
                base_q       <= '0;
            end else if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) frame_active <= 1'b0;
                    else                 row <= row + RW'(1);
                    if (row != '0) base_q <= base_q + LINE_STEP;
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Stage 1 sums the two held window columns with the arriving column.
    always_ff @(posedge pclk) begin
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= ncol[i];
                for (int ch = 0; ch < N_CH; ch++) begin
                    s1_sum[i][ch] <= row_sum(win[i][0][ch*CH_W +: CH_W],
                                             win[i][1][ch*CH_W +: CH_W],
                                             ncol[i][ch*CH_W +: CH_W]);
                end
            end
            s1_centre <= win[1][1];
            s1_pass   <= ~mode_q | (row == RW'(1)) | (col == CW'(1));
            s1_addr   <= base_q + ADDR_W'(col) - ADDR_W'(1);
        end
    end

    always_comb begin
        filt = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            filt[ch*CH_W +: CH_W] = kernel_out(s1_sum[0][ch], s1_sum[1][ch], s1_sum[2][ch]);
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            out_en   <= 1'b0;
            out_data <= '0;
            out_addr <= '0;
        end else begin
            s1_valid <= accept & win_done;
            out_en   <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_pass ? s1_centre : filt;
                out_addr <= s1_addr;
            end
        end
    end
endmodule

// File: tb/tb_pix_gauss3x3.sv
// Directed bench for pix_gauss3x3 on an 8x6 frame.
module tb_pix_gauss3x3;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int AW   = 19;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - 1) * (H - 1);

    logic          pclk = 1'b0;
    logic          rst;
    logic          vsync;
    logic          filt_en;
    logic          pix_en;
    logic [11:0]   pix_data;
    logic          out_en;
    logic [11:0]   out_data;
    logic [AW-1:0] out_addr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_out = 0;
    logic [11:0] img [NPIX];
    logic [11:0] got [NPIX];
    int hits [NPIX];
    int got_cyc [NPIX];
    int in_cyc [NPIX];

    pix_gauss3x3 #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .pclk     (pclk),
        .rst      (rst),
        .vsync    (vsync),
        .filt_en  (filt_en),
        .pix_en   (pix_en),
        .pix_data (pix_data),
        .out_en   (out_en),
        .out_data (out_data),
        .out_addr (out_addr)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (out_en === 1'b1) begin
            n_out++;
            if (int'(out_addr) < NPIX) begin
                hits[int'(out_addr)]++;
                got[int'(out_addr)]     = out_data;
                got_cyc[int'(out_addr)] = cyc;
            end
        end
    end

    function automatic bit is_out(int a);
        return (a / W < H - 1) && (a % W < W - 1);
    endfunction

    // Reference: direct 2-D convolution with weights (2-|dy|)*(2-|dx|).
    function automatic logic [11:0] model_pix(int a, logic mode);
        int cr, cc, s, wt;
        logic [11:0] p, res;
        cr = a / W;
        cc = a % W;
        if (!mode || cr == 0 || cc == 0) return img[a];
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            for (int dy = -1; dy <= 1; dy++) begin
                for (int dx = -1; dx <= 1; dx++) begin
                    wt = (dy == 0 ? 2 : 1) * (dx == 0 ? 2 : 1);
                    p  = img[(cr + dy) * W + cc + dx];
                    s += wt * int'(p[ch*4 +: 4]);
                end
            end
            res[ch*4 +: 4] = 4'(s / 16);
        end
        return res;
    endfunction

    task automatic start_frame();
        n_out = 0;
        for (int i = 0; i < NPIX; i++) hits[i] = 0;
        @(negedge pclk) vsync = 1'b1;
        repeat (2) @(negedge pclk);
        vsync = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic send_frame(input int gap, input int toggle_at);
        start_frame();
        for (int i = 0; i < NPIX; i++) begin
            pix_en   = 1'b1;
            pix_data = img[i];
            in_cyc[i] = cyc;
            @(negedge pclk);
            pix_en = 1'b0;
            if (i == toggle_at) filt_en = ~filt_en;
            repeat (gap) @(negedge pclk);
        end
        repeat (6) @(negedge pclk);
    endtask

    task automatic fill_random(input int seed);
        for (int i = 0; i < NPIX; i++) img[i] = 12'((i * 389 + seed * 1031 + 77) % 4096);
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b0; filt_en = 1'b0; pix_en = 1'b0; pix_data = '0;
        repeat (3) @(negedge pclk);
        checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en got=%b exp=0", out_en); end
        checks++; if (out_data !== 12'h000) begin errors++; $display("FAIL reset_out_data got=%h exp=000", out_data); end
        checks++; if (out_addr !== '0) begin errors++; $display("FAIL reset_out_addr got=%0d exp=0", out_addr); end
        rst = 1'b0;
        repeat (2) @(negedge pclk);
        pix_en = 1'b1; pix_data = 12'hABC;
        repeat (4) @(negedge pclk);
        pix_en = 1'b0;
        repeat (3) @(negedge pclk);
        checks++; if (n_out !== 0) begin errors++; $display("FAIL idle_pix_ignored got=%0d outputs exp=0", n_out); end
    endtask

    task automatic test_uniform();
        for (int i = 0; i < NPIX; i++) img[i] = 12'h5A3;
        filt_en = 1'b1;
        send_frame(1, -1);
        checks++; if (n_out !== NOUT) begin errors++; $display("FAIL uniform_count got=%0d exp=%0d", n_out, NOUT); end
        for (int a = 0; a < NPIX; a++) begin
            checks++;
            if (hits[a] !== (is_out(a) ? 1 : 0)) begin
                errors++; $display("FAIL uniform_hits addr=%0d got=%0d exp=%0d", a, hits[a], is_out(a) ? 1 : 0);
            end else if (is_out(a) && got[a] !== 12'h5A3) begin
                errors++; $display("FAIL uniform_data addr=%0d got=%h exp=5a3", a, got[a]);
            end
        end
    endtask

    task automatic test_impulse();
        for (int i = 0; i < NPIX; i++) img[i] = 12'h000;
        img[2*W + 3] = 12'hFFF;
        filt_en = 1'b1;
        send_frame(2, -1);
        checks++; if (got[19] !== 12'h333) begin errors++; $display("FAIL impulse_centre got=%h exp=333", got[19]); end
        checks++; if (got[11] !== 12'h111) begin errors++; $display("FAIL impulse_n got=%h exp=111", got[11]); end
        checks++; if (got[27] !== 12'h111) begin errors++; $display("FAIL impulse_s got=%h exp=111", got[27]); end
        checks++; if (got[18] !== 12'h111) begin errors++; $display("FAIL impulse_w got=%h exp=111", got[18]); end
        checks++; if (got[20] !== 12'h111) begin errors++; $display("FAIL impulse_e got=%h exp=111", got[20]); end
        checks++;
        if ({got[10], got[12], got[26], got[28]} !== 48'h0) begin
            errors++; $display("FAIL impulse_diag got=%h %h %h %h exp=000", got[10], got[12], got[26], got[28]);
        end
        checks++; if (n_out !== NOUT) begin errors++; $display("FAIL impulse_count got=%0d exp=%0d", n_out, NOUT); end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < NPIX; i++) img[i] = 12'(i);
        filt_en = 1'b0;
        send_frame(1, -1);
        checks++; if (n_out !== NOUT) begin errors++; $display("FAIL ramp_raw_count got=%0d exp=%0d", n_out, NOUT); end
        for (int a = 0; a < NPIX; a++) begin
            if (is_out(a)) begin
                checks++;
                if (hits[a] !== 1 || got[a] !== 12'(a)) begin
                    errors++; $display("FAIL ramp_raw addr=%0d got=%h hits=%0d exp=%h", a, got[a], hits[a], 12'(a));
                end
            end
        end
        filt_en = 1'b1;
        send_frame(0, -1);
        for (int a = 0; a < NPIX; a++) begin
            if (is_out(a)) begin
                checks++;
                if (hits[a] !== 1 || got[a] !== model_pix(a, 1'b1)) begin
                    errors++; $display("FAIL ramp_filt addr=%0d got=%h exp=%h", a, got[a], model_pix(a, 1'b1));
                end
            end
            if (is_out(a) && (a / W == 0 || a % W == 0)) begin
                checks++;
                if (got[a] !== 12'(a)) begin
                    errors++; $display("FAIL ramp_edge_raw addr=%0d got=%h exp=%h", a, got[a], 12'(a));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        fill_random(1);
        filt_en = 1'b1;
        send_frame(0, -1);
        checks++; if (n_out !== NOUT) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", n_out, NOUT); end
        for (int a = 0; a < NPIX; a++) begin
            if (is_out(a)) begin
                checks++;
                if (hits[a] !== 1 || got_cyc[a] - in_cyc[a + W + 1] !== 2) begin
                    errors++; $display("FAIL b2b_latency addr=%0d got=%0d cycles hits=%0d exp=2", a, got_cyc[a] - in_cyc[a + W + 1], hits[a]);
                end
                checks++;
                if (got[a] !== model_pix(a, 1'b1)) begin
                    errors++; $display("FAIL b2b_data addr=%0d got=%h exp=%h", a, got[a], model_pix(a, 1'b1));
                end
            end
        end
    endtask

    task automatic test_filt_toggle();
        fill_random(2);
        filt_en = 1'b1;
        send_frame(1, 20);
        for (int a = 0; a < NPIX; a++) begin
            if (is_out(a)) begin
                checks++;
                if (hits[a] !== 1 || got[a] !== model_pix(a, 1'b1)) begin
                    errors++; $display("FAIL toggle_same_frame addr=%0d got=%h exp=%h", a, got[a], model_pix(a, 1'b1));
                end
            end
        end
        send_frame(1, -1);
        for (int a = 0; a < NPIX; a++) begin
            if (is_out(a)) begin
                checks++;
                if (hits[a] !== 1 || got[a] !== img[a]) begin
                    errors++; $display("FAIL toggle_next_frame addr=%0d got=%h exp=%h", a, got[a], img[a]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        fill_random(3);
        filt_en = 1'b1;
        start_frame();
        for (int i = 0; i < 20; i++) begin
            pix_en = 1'b1; pix_data = img[i];
            @(negedge pclk);
        end
        pix_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        for (int i = 20; i < NPIX; i++) begin
            pix_en = 1'b1; pix_data = img[i];
            @(negedge pclk);
            checks++;
            if (out_en !== 1'b0 || out_data !== 12'h000) begin
                errors++; $display("FAIL post_reset_quiet pix=%0d got en=%b data=%h exp en=0 data=000", i, out_en, out_data);
            end
        end
        pix_en = 1'b0;
        fill_random(4);
        send_frame(1, -1);
        checks++; if (n_out !== NOUT) begin errors++; $display("FAIL post_reset_count got=%0d exp=%0d", n_out, NOUT); end
        for (int a = 0; a < NPIX; a++) begin
            if (is_out(a)) begin
                checks++;
                if (hits[a] !== 1 || got[a] !== model_pix(a, 1'b1)) begin
                    errors++; $display("FAIL post_reset_data addr=%0d got=%h exp=%h", a, got[a], model_pix(a, 1'b1));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) begin
            hits[i] = 0; got[i] = '0; got_cyc[i] = 0; in_cyc[i] = 0;
        end
        test_reset();
        test_uniform();
        test_impulse();
        test_ramp();
        test_back_to_back();
        test_filt_toggle();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
